approx_add_err_monitor: RTL and testbench

- Streaming error-characterisation stage placed directly downstream of an approximate unsigned adder (e.g. a 16-bit, 17-bit-output instance).
- Consumes the adder's operands and its approximate result, recomputes the exact sum, and accumulates statistics over a fixed window of samples: sum of absolute error (MAE numerator), worst-case error (WCE) and erroneous-sample count (EP numerator).
- Used on FPGA to measure approximate adder quality in-system. Results are returned through a valid/ready handshake.

---
 rtl/approx_add_err_monitor_pkg.sv | 22 ++
 rtl/approx_add_err_monitor_if.sv | 39 +++
 rtl/approx_add_err_monitor_absdiff.sv | 17 +
 rtl/approx_add_err_monitor.sv | 128 ++++++++++++
 tb/tb_approx_add_err_monitor.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/approx_add_err_monitor_pkg.sv
// Shared types and width helpers for the approximate-adder error monitor.
package approx_mon_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    REPORT
  } state_t;

  localparam int unsigned DEF_W        = 16;
  localparam int unsigned DEF_LOG2_WIN = 8;

  function automatic int unsigned acc_width(input int unsigned w, input int unsigned log2_win);
    return w + 1 + log2_win;
  endfunction

  function automatic int unsigned sq_width(input int unsigned w, input int unsigned log2_win);
    return 2 * (w + 1) + log2_win;
  endfunction

endpackage

// File: rtl/approx_add_err_monitor_if.sv
// Sample-in / result-out handshake bundle; res_sum_sq exists only with ERR_MON_MSE_EN.
interface approx_add_err_monitor_if #(
  parameter int unsigned W        = approx_mon_pkg::DEF_W,
  parameter int unsigned LOG2_WIN = approx_mon_pkg::DEF_LOG2_WIN
);
  localparam int unsigned ACC_W = approx_mon_pkg::acc_width(W, LOG2_WIN);
  localparam int unsigned SQ_W  = approx_mon_pkg::sq_width(W, LOG2_WIN);

  logic                in_valid;
  logic                in_ready;
  logic [W-1:0]        in_a;
  logic [W-1:0]        in_b;
  logic [W:0]          in_o;
  logic                res_valid;
  logic                res_ready;
  logic [ACC_W-1:0]    res_sum_abs;
  logic [W:0]          res_wce;
  logic [LOG2_WIN:0]   res_err_cnt;
`ifdef ERR_MON_MSE_EN
  logic [SQ_W-1:0]     res_sum_sq;
`endif

  modport master (
    output in_valid, in_a, in_b, in_o, res_ready,
    input  in_ready, res_valid, res_sum_abs, res_wce, res_err_cnt
`ifdef ERR_MON_MSE_EN
    , input res_sum_sq
`endif
  );

  modport slave (
    input  in_valid, in_a, in_b, in_o, res_ready,
    output in_ready, res_valid, res_sum_abs, res_wce, res_err_cnt
`ifdef ERR_MON_MSE_EN
    , output res_sum_sq
`endif
  );

endinterface

// File: rtl/approx_add_err_monitor_absdiff.sv
// Exact sum and absolute error against an approximate adder result (combinational).
module approx_err_absdiff #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W:0]   o,
  output logic [W:0]   exact,
  output logic [W:0]   err
);

  always_comb begin
    exact = {1'b0, a} + {1'b0, b};
    err   = (exact >= o) ? (exact - o) : (o - exact);
  end

endmodule

// File: rtl/approx_add_err_monitor.sv
// Windowed error statistics (sum |err|, max |err|, error count) for an approximate adder.
// Optional squared-error accumulation under ERR_MON_MSE_EN.
module approx_add_err_monitor
  import approx_mon_pkg::*;
#(
  parameter int unsigned W        = DEF_W,
  parameter int unsigned LOG2_WIN = DEF_LOG2_WIN
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                busy,
  approx_add_err_monitor_if.slave mon
);

  localparam int unsigned ACC_W = acc_width(W, LOG2_WIN);
  localparam int unsigned SQ_W  = sq_width(W, LOG2_WIN);
  localparam logic [LOG2_WIN:0] WIN = {1'b1, {LOG2_WIN{1'b0}}};

  state_t              state, state_next;
  logic [LOG2_WIN:0]   cnt;
  logic                accept, in_ready, drain_done;
  logic [W:0]          exact, err, err_q;
  logic                miss_q, s1_valid;
  logic [ACC_W-1:0]    sum_abs;
  logic [W:0]          wce;
  logic [LOG2_WIN:0]   err_cnt;

  approx_err_absdiff #(.W(W)) u_absdiff (
    .a     (mon.in_a),
    .b     (mon.in_b),
    .o     (mon.in_o),
    .exact (exact),
    .err   (err)
  );

  assign accept = mon.in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // RUN holds (in_ready low) until stage 1 empties; DRAIN then covers the remaining stages.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = RUN;
      end
      RUN: begin
        in_ready = (cnt != WIN);
        if (cnt == WIN && !s1_valid) state_next = DRAIN;
      end
      DRAIN: if (drain_done) state_next = REPORT;
      REPORT: if (mon.res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      s1_valid <= 1'b0;
      err_q    <= '0;
      miss_q   <= 1'b0;
      sum_abs  <= '0;
      wce      <= '0;
      err_cnt  <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        err_q  <= err;
        miss_q <= (exact != mon.in_o);
      end
      if (state == IDLE && start) begin
        cnt     <= '0;
        sum_abs <= '0;
        wce     <= '0;
        err_cnt <= '0;
      end else begin
        if (accept) cnt <= cnt + 1'b1;
        if (s1_valid) begin
          sum_abs <= sum_abs + ACC_W'(err_q);
          if (err_q > wce) wce <= err_q;
          err_cnt <= err_cnt + (LOG2_WIN + 1)'(miss_q);
        end
      end
    end
  end

`ifdef ERR_MON_MSE_EN
  logic [2*W+1:0] sq_q;
  logic           mul_valid, drain_cnt;
  logic [SQ_W-1:0] sum_sq;

  assign drain_done = drain_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sq_q      <= '0;
      mul_valid <= 1'b0;
      drain_cnt <= 1'b0;
      sum_sq    <= '0;
    end else begin
      mul_valid <= s1_valid;
      if (s1_valid) sq_q <= {{(W+1){1'b0}}, err_q} * {{(W+1){1'b0}}, err_q};
      drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
      if (state == IDLE && start) sum_sq <= '0;
      else if (mul_valid)         sum_sq <= sum_sq + SQ_W'(sq_q);
    end
  end

  assign mon.res_sum_sq = sum_sq;
`else
  assign drain_done = 1'b1;
`endif

  assign mon.in_ready    = in_ready;
  assign mon.res_valid   = (state == REPORT);
  assign mon.res_sum_abs = sum_abs;
  assign mon.res_wce     = wce;
  assign mon.res_err_cnt = err_cnt;

endmodule

// File: tb/tb_approx_add_err_monitor.sv
// Directed window tests for approx_add_err_monitor (result values, latency, handshake, reset).
module tb_approx_add_err_monitor;
  import approx_mon_pkg::*;

  localparam int unsigned W  = 16;
  localparam int unsigned LW = 8;
  localparam int NWIN = 256;
`ifdef ERR_MON_MSE_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy;

  always #5 clk = ~clk;

  approx_add_err_monitor_if #(.W(W), .LOG2_WIN(LW)) ifc ();

  approx_add_err_monitor #(.W(W), .LOG2_WIN(LW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .busy  (busy),
    .mon   (ifc.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    int          mode;
    bit          gaps;
    bit          start_mid;
    logic [63:0] e_sum;
    logic [63:0] e_wce;
    logic [63:0] e_cnt;
    logic [63:0] e_sq;
  } vec_t;

  vec_t vecs[5];

  task automatic gen(input int mode, input int i,
                     output logic [15:0] a, output logic [15:0] b, output logic [16:0] o);
    a = 16'd0; b = 16'd0; o = 17'd0;
    case (mode)
      0: begin a = 16'($urandom); b = 16'($urandom); o = {1'b0, a} + {1'b0, b}; end
      1: begin a = 16'h0100; b = 16'h0000; o = 17'd0; end
      2: begin a = 16'hFFFF; b = 16'hFFFF; o = 17'd0; end
      3: begin a = 16'd5; b = 16'd3; o = 17'd9; end
      default: begin
        a = 16'(i); b = 16'd0;
        if (i % 4 == 1)      o = {1'b0, a} + 17'd3;
        else if (i % 4 == 3) o = {1'b0, a} - 17'd2;
        else                 o = {1'b0, a};
      end
    endcase
  endtask

  // Feeds n accepted samples; returns with time at #1 after the final accepting edge.
  task automatic feed(input int mode, input bit gaps, input bit start_mid, input int n);
    logic [15:0] a, b;
    logic [16:0] o;
    logic v, rdy;
    int acc = 0;
    int cyc = 0;
    while (acc < n && cyc < 4000) begin
      gen(mode, acc, a, b, o);
      ifc.in_a = a; ifc.in_b = b; ifc.in_o = o;
      v = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
      ifc.in_valid = v;
      start = (start_mid && acc == 50 && cyc % 2 == 0);
      rdy = ifc.in_ready;
      @(posedge clk); #1;
      cyc++;
      if (v && rdy) acc++;
    end
    start = 1'b0;
    ifc.in_valid = 1'b0;
    chk("accepted_samples", 64'(acc), 64'(n));
  endtask

  task automatic check_results(input string tag, input vec_t v);
    chk({tag, "_sum_abs"}, 64'(ifc.res_sum_abs), v.e_sum);
    chk({tag, "_wce"},     64'(ifc.res_wce),     v.e_wce);
    chk({tag, "_err_cnt"}, 64'(ifc.res_err_cnt), v.e_cnt);
`ifdef ERR_MON_MSE_EN
    chk({tag, "_sum_sq"},  64'(ifc.res_sum_sq),  v.e_sq);
`endif
  endtask

  task automatic run_window(input vec_t v, input bit hold);
    int n;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
    chk("in_ready_run", 64'(ifc.in_ready), 64'd1);
    feed(v.mode, v.gaps, v.start_mid, NWIN);
    // junk offered after the window is full must never be taken
    ifc.in_a = 16'hFFFF; ifc.in_b = 16'hFFFF; ifc.in_o = 17'd0; ifc.in_valid = 1'b1;
    n = 0;
    while (!ifc.res_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    ifc.in_valid = 1'b0;
    chk("res_valid_latency", 64'(n), 64'(LAT));
    chk("in_ready_report", 64'(ifc.in_ready), 64'd0);
    check_results("report", v);
    if (hold) begin
      repeat (10) begin @(posedge clk); #1; end
      chk("hold_res_valid", 64'(ifc.res_valid), 64'd1);
      check_results("hold", v);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("start_in_report_valid", 64'(ifc.res_valid), 64'd1);
      chk("start_in_report_busy", 64'(busy), 64'd1);
      check_results("start_in_report", v);
    end
    ifc.res_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    ifc.res_ready = 1'b0;
    start = 1'b0;
    chk("idle_res_valid", 64'(ifc.res_valid), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    chk("start_with_ready_ignored", 64'(busy), 64'd0);
    check_results("persist", v);
  endtask

  initial begin
    vecs[0] = '{0, 1'b0, 1'b0, 64'd0,        64'd0,      64'd0,   64'd0};
    vecs[1] = '{1, 1'b1, 1'b1, 64'd65536,    64'd256,    64'd256, 64'd16777216};
    vecs[2] = '{2, 1'b0, 1'b0, 64'd33553920, 64'd131070, 64'd256, 64'd4397912294400};
    vecs[3] = '{3, 1'b1, 1'b0, 64'd256,      64'd1,      64'd256, 64'd256};
    vecs[4] = '{4, 1'b0, 1'b1, 64'd320,      64'd3,      64'd128, 64'd832};

    ifc.in_valid = 1'b0; ifc.in_a = '0; ifc.in_b = '0; ifc.in_o = '0; ifc.res_ready = 1'b0;
    #3;
    chk("rst_in_ready", 64'(ifc.in_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_res_valid", 64'(ifc.res_valid), 64'd0);
    chk("rst_sum_abs", 64'(ifc.res_sum_abs), 64'd0);
    chk("rst_wce", 64'(ifc.res_wce), 64'd0);
    chk("rst_err_cnt", 64'(ifc.res_err_cnt), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_no_start", 64'(busy), 64'd0);

    for (int k = 0; k < 5; k++) run_window(vecs[k], k == 2);

    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    feed(1, 1'b0, 1'b0, 100);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_res_valid", 64'(ifc.res_valid), 64'd0);
    chk("midrst_in_ready", 64'(ifc.in_ready), 64'd0);
    chk("midrst_sum_abs", 64'(ifc.res_sum_abs), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_window(vecs[3], 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
